// File: rtl/sdio_cmdrx.sv
// Passive SD CMD-line receiver: oversamples sd_ck/sd_cmd on i_clk and deframes
// 48-bit command/response tokens, reporting fields, CRC7 status and counters.
module sdio_cmdrx #(
  parameter int unsigned OPT_SYNC  = 1,
  parameter int unsigned LGTIMEOUT = 10
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_sd_ck,
  input  logic        i_sd_cmd,
  output logic        o_busy,
  output logic        o_valid,
  output logic        o_dir,
  output logic [5:0]  o_index,
  output logic [31:0] o_arg,
  output logic [6:0]  o_crc,
  output logic        o_crc_err,
  output logic        o_frame_err,
  output logic [15:0] o_nframes,
  output logic [15:0] o_nerrors
);

  typedef enum logic [1:0] {StIdle, StRx, StDone} state_e;

  localparam logic [LGTIMEOUT-1:0] TmoOne = 1;

  logic ck_s, cmd_s, ck_prev_q, strobe;

  if (OPT_SYNC != 0) begin : g_sync
    logic [1:0] ck_pipe_q, cmd_pipe_q;
    always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
        ck_pipe_q  <= 2'b00;
        cmd_pipe_q <= 2'b11;
      end else begin
        ck_pipe_q  <= {ck_pipe_q[0], i_sd_ck};
        cmd_pipe_q <= {cmd_pipe_q[0], i_sd_cmd};
      end
    end
    assign ck_s  = ck_pipe_q[1];
    assign cmd_s = cmd_pipe_q[1];
  end else begin : g_raw
    assign ck_s  = i_sd_ck;
    assign cmd_s = i_sd_cmd;
  end

  assign strobe = ck_s & ~ck_prev_q;

  state_e               state_q, state_d;
  logic [5:0]           bitcnt_q, bitcnt_d;
  // Start bit is never stored; sr_q[46] is the direction bit of a full frame.
  logic [46:0]          sr_q, sr_d, sr_shift;
  logic [6:0]           crc_q, crc_d, crc_upd;
  logic [LGTIMEOUT-1:0] tmo_q, tmo_d;
  logic                 fin, abort, crc_bad, err_now;

  assign sr_shift = {sr_q[45:0], cmd_s};
  assign crc_upd  = {crc_q[5:0], 1'b0} ^ ((cmd_s ^ crc_q[6]) ? 7'h09 : 7'h00);
  assign crc_bad  = (sr_shift[7:1] != crc_q);
  assign err_now  = abort | ~cmd_s | crc_bad;
  assign o_busy   = (state_q == StRx);

  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    sr_d     = sr_q;
    crc_d    = crc_q;
    tmo_d    = '0;
    fin      = 1'b0;
    abort    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (strobe && !cmd_s) begin
          state_d  = StRx;
          bitcnt_d = 6'd1;
          sr_d     = '0;
          crc_d    = 7'h00;
        end
      end
      StRx: begin
        if (strobe) begin
          sr_d     = sr_shift;
          bitcnt_d = bitcnt_q + 6'd1;
          if (bitcnt_q <= 6'd39) crc_d = crc_upd;
          if (bitcnt_q == 6'd47) begin
            state_d = StDone;
            fin     = 1'b1;
          end
        end else if (tmo_q == '1) begin
          state_d = StIdle;
          abort   = 1'b1;
        end else begin
          tmo_d = tmo_q + TmoOne;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      ck_prev_q   <= 1'b0;
      state_q     <= StIdle;
      bitcnt_q    <= '0;
      sr_q        <= '0;
      crc_q       <= '0;
      tmo_q       <= '0;
      o_valid     <= 1'b0;
      o_dir       <= 1'b0;
      o_index     <= '0;
      o_arg       <= '0;
      o_crc       <= '0;
      o_crc_err   <= 1'b0;
      o_frame_err <= 1'b0;
      o_nframes   <= '0;
      o_nerrors   <= '0;
    end else begin
      ck_prev_q <= ck_s;
      state_q   <= state_d;
      bitcnt_q  <= bitcnt_d;
      sr_q      <= sr_d;
      crc_q     <= crc_d;
      tmo_q     <= tmo_d;
      o_valid   <= fin | abort;
      if (fin) begin
        o_dir       <= sr_shift[46];
        o_index     <= sr_shift[45:40];
        o_arg       <= sr_shift[39:8];
        o_crc       <= sr_shift[7:1];
        o_crc_err   <= crc_bad;
        o_frame_err <= ~cmd_s;
      end else if (abort) begin
        o_dir       <= sr_q[46];
        o_index     <= sr_q[45:40];
        o_arg       <= sr_q[39:8];
        o_crc       <= sr_q[7:1];
        o_crc_err   <= 1'b0;
        o_frame_err <= 1'b1;
      end
      if (fin || abort) begin
        o_nframes <= o_nframes + 16'd1;
        if (err_now && (o_nerrors != 16'hffff)) o_nerrors <= o_nerrors + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_sdio_cmdrx.sv
// Randomized bench for sdio_cmdrx against a frame-level reference model.
module tb_sdio_cmdrx;

  logic        clk = 1'b0;
  logic        rst;
  logic        sd_ck, sd_cmd;
  logic        busy, valid, dir, crc_err, frame_err;
  logic [5:0]  index;
  logic [31:0] arg;
  logic [6:0]  crc;
  logic [15:0] nframes, nerrors;

  int nchecks = 0;
  int nerr = 0;
  int exp_nframes = 0;
  int exp_nerrors = 0;
  logic [47:0] obs_q[$];
  logic [47:0] exp_q[$];

  always #5 clk = ~clk;

  sdio_cmdrx #(.OPT_SYNC(1), .LGTIMEOUT(10)) dut (
    .i_clk(clk), .i_reset(rst), .i_sd_ck(sd_ck), .i_sd_cmd(sd_cmd),
    .o_busy(busy), .o_valid(valid), .o_dir(dir), .o_index(index), .o_arg(arg),
    .o_crc(crc), .o_crc_err(crc_err), .o_frame_err(frame_err),
    .o_nframes(nframes), .o_nerrors(nerrors)
  );

  always @(negedge clk) begin
    if (valid) obs_q.push_back({dir, index, arg, crc, crc_err, frame_err});
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nchecks++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // CRC7 as the remainder of m(x)*x^7 divided by x^7+x^3+1.
  function automatic logic [6:0] crc7(input logic [39:0] m);
    logic [46:0] r;
    r = {m, 7'b0};
    for (int i = 46; i >= 7; i--)
      if (r[i]) r = r ^ (47'h89 << (i - 7));
    return r[6:0];
  endfunction

  function automatic logic [47:0] mk_frame(input logic [5:0] idx, input logic [31:0] a);
    logic [39:0] head;
    head = {2'b01, idx, a};
    return {head, crc7(head), 1'b1};
  endfunction

  task automatic expect_frame(input logic [47:0] f);
    logic ce, fe;
    ce = (crc7(f[47:8]) != f[7:1]);
    fe = ~f[0];
    exp_q.push_back({f[46], f[45:40], f[39:8], f[7:1], ce, fe});
    exp_nframes = (exp_nframes + 1) % 65536;
    if ((ce || fe) && exp_nerrors < 65535) exp_nerrors++;
  endtask

  task automatic sd_bit(input logic b);
    sd_ck  = 1'b0;
    sd_cmd = b;
    repeat ($urandom_range(2, 4)) @(negedge clk);
    sd_ck = 1'b1;
    repeat ($urandom_range(2, 4)) @(negedge clk);
  endtask

  task automatic send_bits(input logic [47:0] f, input int n);
    for (int i = 47; i > 47 - n; i--) sd_bit(f[i]);
  endtask

  task automatic send_frame(input logic [47:0] f);
    send_bits(f, 48);
    expect_frame(f);
  endtask

  task automatic drain(input string tag);
    int budget;
    budget = 0;
    while (obs_q.size() < exp_q.size() && budget < 100) begin
      @(negedge clk);
      budget++;
    end
    repeat (20) @(negedge clk);
    check({tag, "_nvalid"}, 64'(obs_q.size()), 64'(exp_q.size()));
    while (obs_q.size() > 0 && exp_q.size() > 0)
      check({tag, "_rec"}, 64'(obs_q.pop_front()), 64'(exp_q.pop_front()));
    obs_q.delete();
    exp_q.delete();
    check({tag, "_cnt"}, {32'h0, nframes, nerrors}, {32'h0, 16'(exp_nframes), 16'(exp_nerrors)});
    check({tag, "_busy"}, 64'(busy), 64'd0);
  endtask

  initial begin
    logic [47:0] f, f2;
    logic [19:0] p;
    int n;
    rst = 1'b1; sd_ck = 1'b0; sd_cmd = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_outs", {busy, valid, dir, index, arg, crc, crc_err, frame_err}, 64'd0);
    check("reset_cnt", {nframes, nerrors}, 64'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    f = mk_frame(6'd0, 32'h0);
    check("cmd0_crc_model", 64'(f[7:1]), 64'h4a);
    send_frame(f);
    drain("cmd0");

    f = mk_frame(6'd8, 32'h1aa);
    send_frame(f);
    drain("cmd8");

    f = mk_frame(6'd17, 32'h0);
    f[7:0] = 8'h57;
    send_frame(f);
    drain("cmd17_badcrc");

    f = mk_frame(6'd0, 32'h0);
    f[0] = 1'b0;
    send_frame(f);
    drain("cmd0_badend");
    send_frame(mk_frame(6'd8, 32'h1aa));
    drain("cmd8_after");

    // Timeout: clock stops after 20 bits.
    f = mk_frame(6'd8, 32'h1aa);
    p = f[47:28];
    send_bits(f, 20);
    sd_ck = 1'b0;
    @(negedge clk);
    check("tmo_busy", 64'(busy), 64'd1);
    n = 0;
    while (!valid && n < 1200) begin
      @(negedge clk);
      n++;
    end
    check("tmo_latency_ok", 64'((n >= 990) && (n <= 1030)), 64'd1);
    exp_q.push_back({1'b0, 6'd0, 32'(p >> 8), 7'(p >> 1), 1'b0, 1'b1});
    exp_nframes++;
    exp_nerrors++;
    drain("tmo");
    send_frame(mk_frame(6'd0, 32'h0));
    drain("cmd0_after_tmo");

    // Asynchronous reset mid-frame.
    send_bits(mk_frame(6'd8, 32'h1aa), 25);
    #2 rst = 1'b1;
    #1;
    check("midrst_outs", {busy, valid, dir, index, arg, crc, crc_err, frame_err}, 64'd0);
    check("midrst_cnt", {nframes, nerrors}, 64'd0);
    @(negedge clk);
    sd_cmd = 1'b1;
    rst = 1'b0;
    exp_nframes = 0;
    exp_nerrors = 0;
    obs_q.delete();
    repeat (4) @(negedge clk);
    send_frame(mk_frame(6'd0, 32'h0));
    drain("cmd0_after_rst");
    send_frame(mk_frame(6'd0, 32'h0));
    send_frame(mk_frame(6'd8, 32'h1aa));
    drain("b2b");

    for (int k = 0; k < 30; k++) begin
      f = mk_frame(6'($urandom), $urandom);
      if ($urandom_range(0, 3) == 0) f[7:1] = f[7:1] ^ 7'($urandom_range(1, 127));
      if ($urandom_range(0, 7) == 0) f[0] = 1'b0;
      f[46] = 1'($urandom);
      send_frame(f);
      if ($urandom_range(0, 1) == 0) begin
        f2 = mk_frame(6'($urandom), $urandom);
        send_frame(f2);
      end
      drain("rand");
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchecks);
    $finish;
  end

endmodule
